// File: rtl/mulu_m7q7_pkg.sv
// Shared constants and FSM encoding for the 7x7 unsigned serial-load
// shift-add multiplier tile.
package mulu_m7q7_pkg;
    localparam int OPW = 7;
    localparam int PW  = 14;
    localparam int CW  = 3;

    // cnt value on the 7th load beat and on the 7th calc edge
    localparam logic [CW-1:0] LAST_CNT = CW'(OPW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/mulu_m7q7_if.sv
// Tile pin bus: 8 inputs (clock and reset included) and 8 outputs.
interface mulu_m7q7_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);
endinterface

// File: rtl/mulu_m7q7_core.sv
// Shift-add datapath: serial operand registers, product accumulator and
// the shared beat/step counter.
module mulu_m7q7_core
    import mulu_m7q7_pkg::*;
(
    input  logic          clk,
    input  logic          srst,
    input  logic          shift_en_i,
    input  logic          clr_en_i,
    input  logic          calc_en_i,
    input  logic          a_sdi_i,
    input  logic          b_sdi_i,
    output logic [CW-1:0] cnt_o,
    output logic [PW-1:0] p_o
);
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [PW-1:0]  p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        if (shift_en_i) begin
            a_d = {a_sdi_i, a_q[OPW-1:1]};
            b_d = {b_sdi_i, b_q[OPW-1:1]};
            // A clearing beat is always beat 1 of a fresh operand pair
            if (clr_en_i) begin
                p_d   = '0;
                cnt_d = CW'(1);
            end else if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (calc_en_i) begin
            if (b_q[0]) begin
                p_d = p_q + (PW'(a_q) << cnt_q);
            end
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign p_o   = p_q;
endmodule

// File: rtl/mulu_m7q7.sv
// Multiplier tile top: unpacks the pin bus, sequences load/calc/done and
// drives the byte-select output mux.
module mulu_m7q7
    import mulu_m7q7_pkg::*;
(
    mulu_m7q7_if.slave tile
);
    logic clk;
    logic srst;
    logic load;
    logic a_sdi;
    logic b_sdi;
    logic out_sel;
    logic unused_pins;

    assign clk         = tile.io_in[0];
    assign srst        = tile.io_in[1];
    assign load        = tile.io_in[2];
    assign a_sdi       = tile.io_in[3];
    assign b_sdi       = tile.io_in[4];
    assign out_sel     = tile.io_in[5];
    assign unused_pins = &tile.io_in[7:6];

    state_e        state_q, state_d;
    logic          shift_en, clr_en, calc_en;
    logic [CW-1:0] cnt;
    logic [PW-1:0] p;
    logic          busy, done;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        clr_en   = 1'b0;
        calc_en  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    shift_en = 1'b1;
                    clr_en   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (load) begin
                    shift_en = 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                calc_en = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

    mulu_m7q7_core u_core (
        .clk        (clk),
        .srst       (srst),
        .shift_en_i (shift_en),
        .clr_en_i   (clr_en),
        .calc_en_i  (calc_en),
        .a_sdi_i    (a_sdi),
        .b_sdi_i    (b_sdi),
        .cnt_o      (cnt),
        .p_o        (p)
    );

    always_comb begin
        tile.io_out = out_sel ? {done, busy, p[PW-1:8]} : p[7:0];
    end
endmodule

// File: tb/tb_mulu_m7q7.sv
// Directed-vector bench for the 7x7 multiplier tile; expected products are
// hand-computed constants.
module tb_mulu_m7q7;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load = 1'b0;
    logic a_sdi = 1'b0;
    logic b_sdi = 1'b0;
    logic out_sel = 1'b0;

    int vectors = 0;
    int errs = 0;

    mulu_m7q7_if tile ();
    assign tile.io_in = {2'b00, out_sel, b_sdi, a_sdi, load, rst, clk};

    mulu_m7q7 dut (.tile(tile));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, output logic [7:0] v);
        out_sel = sel;
        #1;
        v = tile.io_out;
    endtask

    task automatic load_op(input int a, input int b, input int pause_after);
        for (int i = 0; i < 7; i++) begin
            load  = 1'b1;
            a_sdi = a[i];
            b_sdi = b[i];
            tick();
            if (i == pause_after) begin
                load  = 1'b0;
                a_sdi = ~a_sdi;
                b_sdi = ~b_sdi;
                repeat (3) tick();
            end
        end
        load = 1'b0;
    endtask

    // Counts busy cycles until done; with jitter, load/sdi wiggle during CALC.
    task automatic run_calc(input bit jitter, output int busy_n, output bit ok);
        logic [7:0] v;
        busy_n = 0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rd(1'b1, v);
            if (v[7]) begin
                ok = 1'b1;
                break;
            end
            if (v[6]) busy_n++;
            if (jitter) begin
                load  = 1'($urandom_range(0, 1));
                a_sdi = 1'($urandom_range(0, 1));
                b_sdi = 1'($urandom_range(0, 1));
            end
            tick();
        end
        load  = 1'b0;
        a_sdi = 1'b0;
        b_sdi = 1'b0;
    endtask

    task automatic op(input string tag, input int a, input int b, input int pause_after,
                      input bit jitter, input logic [13:0] exp_p);
        int busy_n;
        bit ok;
        logic [7:0] v;
        load_op(a, b, pause_after);
        run_calc(jitter, busy_n, ok);
        chk({tag, " done"}, 16'(ok), 16'd1);
        chk({tag, " busy_cycles"}, 16'(busy_n), 16'd7);
        rd(1'b0, v);
        chk({tag, " lo"}, 16'(v), 16'(exp_p[7:0]));
        rd(1'b1, v);
        chk({tag, " hi"}, 16'(v), 16'({2'b10, exp_p[13:8]}));
    endtask

    initial begin
        logic [7:0] v;
        int busy_n;
        bit ok;
        int three;

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        rd(1'b0, v);
        chk("reset lo", 16'(v), 16'h00);
        rd(1'b1, v);
        chk("reset hi", 16'(v), 16'h00);

        op("5x3", 5, 3, -1, 1'b0, 14'd15);
        op("127x127", 127, 127, -1, 1'b0, 14'd16129);
        op("0x100", 0, 100, -1, 1'b0, 14'd0);
        op("9x11 paused", 9, 11, 3, 1'b0, 14'd99);

        // Reset in the middle of CALC
        load_op(127, 127, -1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(1'b0, v);
        chk("rst mid-calc lo", 16'(v), 16'h00);
        rd(1'b1, v);
        chk("rst mid-calc hi", 16'(v), 16'h00);

        op("2x2", 2, 2, -1, 1'b0, 14'd4);
        op("6x7 jitter", 6, 7, -1, 1'b1, 14'd42);

        // First beat of a new load after done clears done and P
        three = 3;
        load  = 1'b1;
        a_sdi = 1'b1;
        b_sdi = 1'b1;
        tick();
        load = 1'b0;
        rd(1'b1, v);
        chk("new beat hi", 16'(v), 16'h00);
        rd(1'b0, v);
        chk("new beat lo", 16'(v), 16'h00);
        for (int i = 1; i < 7; i++) begin
            load  = 1'b1;
            a_sdi = three[i];
            b_sdi = three[i];
            tick();
        end
        load = 1'b0;
        run_calc(1'b0, busy_n, ok);
        chk("3x3 done", 16'(ok), 16'd1);
        rd(1'b0, v);
        chk("3x3 lo", 16'(v), 16'h09);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
